dlfloat_link_host: RTL

//  Host-side initiator for the DLFloat16 MAC byte-link. Accepts operand pairs on
//  a valid/ready port and drives them onto the 16-bit link as two beats (A then
//  B). It captures the 8-bit result stream (high byte, then low byte) and

---
 rtl/dlfloat_link_host.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dlfloat_link_host.sv
`default_nettype none
// ============================================================================
//  Module      : dlfloat_link_host
//  Description : Host-side initiator for the DLFloat16 MAC byte-link. Sends
//                operand pairs as A/B beats on a two-phase 16-bit link and
//                reassembles the returned hi/lo result bytes into a 2-entry
//                first-word-fall-through result FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module dlfloat_link_host #(
  parameter int RES_LAT = 4,
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic [15:0] link_data,
  input  logic [7:0]  link_byte,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        busy
);

  // Reject parameter values the link framing cannot support.
  generate
    if (RES_LAT < 2 || (RES_LAT % 2) != 0) begin : g_bad_res_lat
      $error("dlfloat_link_host: RES_LAT must be even and >= 2");
    end
    if (MAX_OUT < 1 || MAX_OUT > 2) begin : g_bad_max_out
      $error("dlfloat_link_host: MAX_OUT must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ALIGN  = 2'd1,
    S_SEND_A = 2'd2,
    S_SEND_B = 2'd3
  } state_t;

  localparam logic [1:0] C_MAX_OUT = 2'(MAX_OUT);

  state_t             r_state;
  logic               r_ph;
  logic [15:0]        r_a;
  logic [15:0]        r_b;
  logic [15:0]        r_link;
  logic [RES_LAT-1:0] r_dl;
  logic [7:0]         r_hi;
  logic               r_lo_pend;
  logic [15:0]        r_fifo0;
  logic [15:0]        r_fifo1;
  logic [1:0]         r_cnt;
  logic [1:0]         r_outst;

  logic               w_accept;
  logic               w_pop;
  logic               w_push;
  logic [15:0]        w_new;
  logic               w_dl_out;

  assign op_ready  = rst_n & (r_state == S_IDLE) & (r_outst < C_MAX_OUT);
  assign w_accept  = op_valid & op_ready;
  assign res_valid = (r_cnt != 2'd0);
  assign res_data  = res_valid ? r_fifo0 : 16'h0000;
  assign w_pop     = res_valid & res_ready;
  assign w_push    = r_lo_pend;
  assign w_new     = {r_hi, link_byte};
  assign w_dl_out  = r_dl[RES_LAT-1];
  assign link_data = r_link;
  assign busy      = (r_outst != 2'd0);

  // Free-running phase: even cycles are A-beat slots, odd cycles B-beat slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ph <= 1'b0;
    else        r_ph <= ~r_ph;
  end

  // Beat sequencer: latches operands and drives the registered link word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= 16'h0000;
      r_b     <= 16'h0000;
      r_link  <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_link <= 16'h0000;
          if (w_accept) begin
            r_a <= op_a;
            r_b <= op_b;
            if (r_ph) begin
              // Next cycle is an A slot: send A straight away.
              r_state <= S_SEND_A;
              r_link  <= op_a;
            end else begin
              // Next cycle is a B slot: burn it with a null operand.
              r_state <= S_ALIGN;
            end
          end
        end
        S_ALIGN: begin
          r_state <= S_SEND_A;
          r_link  <= r_a;
        end
        S_SEND_A: begin
          r_state <= S_SEND_B;
          r_link  <= r_b;
        end
        default: begin
          r_state <= S_IDLE;
          r_link  <= 16'h0000;
        end
      endcase
    end
  end

  // Valid-bit delay line marking which odd cycle carries a result high byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dl <= '0;
    else        r_dl <= {r_dl[RES_LAT-2:0], (r_state == S_SEND_B)};
  end

  // Result byte capture: high byte in the odd cycle, low byte one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi      <= 8'h00;
      r_lo_pend <= 1'b0;
    end else begin
      r_lo_pend <= w_dl_out & r_ph;
      if (w_dl_out & r_ph) r_hi <= link_byte;
    end
  end

  // Two-entry shifting FIFO; r_fifo0 is always the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo0 <= 16'h0000;
      r_fifo1 <= 16'h0000;
      r_cnt   <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_fifo0 <= w_new;
          else               r_fifo1 <= w_new;
          if (r_cnt != 2'd2) r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_fifo0 <= r_fifo1;
          r_cnt   <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_fifo0 <= w_new;
          end else begin
            r_fifo0 <= r_fifo1;
            r_fifo1 <= w_new;
          end
        end
        default: ;
      endcase
    end
  end

  // Outstanding-op count: issued operand pairs whose result is not yet popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outst <= 2'd0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_outst <= r_outst + 2'd1;
        2'b01:   r_outst <= r_outst - 2'd1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
